// File: rtl/life_next_gen_if.sv
// Handshake and row-bus bundle between the next-generation engine and its environment.
// Combinational bundle; no latency of its own.
// No backpressure: a start pulse is a one-shot request and the row ports are plain buses.
interface life_next_gen_if;
  logic       start;
  logic [2:0] ra;
  logic [7:0] rd;
  logic [2:0] wa;
  logic [7:0] wd;
  logic       regwrite;
  logic       busy;
  logic       done;
  logic [6:0] pop;
  logic [7:0] gen;

  // Engine side: receives start and current-state read data, drives everything else.
  modport slave (
    input  start, rd,
    output ra, wa, wd, regwrite, busy, done, pop, gen
  );

  // Controller / register-file side.
  modport master (
    output start, rd,
    input  ra, wa, wd, regwrite, busy, done, pop, gen
  );
endinterface

// File: rtl/life_next_gen.sv
// Computes one Conway generation of an 8x8 board, row by row, into the next-state file.
// Latency: 34 cycles from accepted start to IDLE (4 cycles per row, done in cycle 33).
// No backpressure: start is only sampled in IDLE; a start during a pass is dropped.
module life_next_gen #(
  parameter int WRAP = 1
) (
  input  logic           ph1,
  input  logic           reset,
  life_next_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_UP, RD_MID, RD_DN, WRITE, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] up_q, up_d;
  logic [7:0] mid_q, mid_d;
  logic [2:0] wa_q, wa_d;
  logic [7:0] wd_q, wd_d;
  logic       regwrite_q, regwrite_d;
  logic       done_q, done_d;
  logic [6:0] acc_q, acc_d;
  logic [6:0] pop_q, pop_d;
  logic [7:0] gen_q, gen_d;
  logic [2:0] ra;
  logic [7:0] dn_eff;

  // Applies the Conway rule to every column of the middle row.
  function automatic logic [7:0] next_row(input logic [7:0] up, input logic [7:0] mid,
                                          input logic [7:0] dn);
    logic [7:0] nr;
    logic [3:0] n;
    logic [2:0] cc, cl, cr;
    logic       wl, wr;
    nr = '0;
    for (int c = 0; c < 8; c++) begin
      cc = 3'(c);
      cl = cc - 3'd1;   // wraps to column 7 at c=0
      cr = cc + 3'd1;   // wraps to column 0 at c=7
      // With a dead border the wrapped-around column must not contribute.
      wl = (WRAP != 0) || (c != 0);
      wr = (WRAP != 0) || (c != 7);
      n = 4'(up[cl] & wl) + 4'(up[cc]) + 4'(up[cr] & wr)
        + 4'(mid[cl] & wl) + 4'(mid[cr] & wr)
        + 4'(dn[cl] & wl) + 4'(dn[cc]) + 4'(dn[cr] & wr);
      nr[cc] = (n == 4'd3) | (mid[cc] & (n == 4'd2));
    end
    return nr;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + 4'(v[i]);
    return s;
  endfunction

  // Next-state, read address and write-port update for the row sequencer.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    up_d       = up_q;
    mid_d      = mid_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    regwrite_d = 1'b0;
    done_d     = 1'b0;
    acc_d      = acc_q;
    pop_d      = pop_q;
    gen_d      = gen_q;
    ra         = 3'd0;
    dn_eff     = 8'd0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          row_d   = 3'd0;
          acc_d   = 7'd0;
          state_d = RD_UP;
        end
      end
      RD_UP: begin
        ra      = row_q - 3'd1;
        up_d    = (WRAP == 0 && row_q == 3'd0) ? 8'd0 : bus.rd;
        state_d = RD_MID;
      end
      RD_MID: begin
        ra      = row_q;
        mid_d   = bus.rd;
        state_d = RD_DN;
      end
      RD_DN: begin
        // The row below goes straight into the rule; the result is registered
        // so wa/wd/regwrite are clean flop outputs in the WRITE cycle.
        ra         = row_q + 3'd1;
        dn_eff     = (WRAP == 0 && row_q == 3'd7) ? 8'd0 : bus.rd;
        wa_d       = row_q;
        wd_d       = next_row(up_q, mid_q, dn_eff);
        regwrite_d = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        acc_d = acc_q + 7'(popcount8(wd_q));
        if (row_q == 3'd7) begin
          done_d  = 1'b1;
          pop_d   = acc_d;
          gen_d   = gen_q + 8'd1;
          state_d = DONE;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = RD_UP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      up_q       <= 8'd0;
      mid_q      <= 8'd0;
      wa_q       <= 3'd0;
      wd_q       <= 8'd0;
      regwrite_q <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= 7'd0;
      pop_q      <= 7'd0;
      gen_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      up_q       <= up_d;
      mid_q      <= mid_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      regwrite_q <= regwrite_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      pop_q      <= pop_d;
      gen_q      <= gen_d;
    end
  end

  assign bus.ra       = ra;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.regwrite = regwrite_q;
  assign bus.done     = done_q;
  assign bus.pop      = pop_q;
  assign bus.gen      = gen_q;
  assign bus.busy     = (state_q == RD_UP) || (state_q == RD_MID) ||
                        (state_q == RD_DN) || (state_q == WRITE);

endmodule

// File: tb/tb_life_next_gen.sv
// Self-checking bench: two engines (toroidal and dead-border) read one shared board.
// Every pass is compared cycle by cycle against a cell-level neighbour-count model.
// Boards come from the directed patterns, then from $urandom until gen wraps.
module tb_life_next_gen;

  logic ph1 = 1'b0;
  logic reset;
  always #5 ph1 = ~ph1;

  life_next_gen_if ifw ();
  life_next_gen_if ifd ();

  life_next_gen #(.WRAP(1)) dut_w (.ph1(ph1), .reset(reset), .bus(ifw.slave));
  life_next_gen #(.WRAP(0)) dut_d (.ph1(ph1), .reset(reset), .bus(ifd.slave));

  // Current-state file (combinational read) and the two next-state files.
  logic [7:0] cur [8];
  logic [7:0] nxt_w [8];
  logic [7:0] nxt_d [8];
  assign ifw.rd = cur[ifw.ra];
  assign ifd.rd = cur[ifd.ra];

  always_ff @(posedge ph1) begin
    if (ifw.regwrite) nxt_w[ifw.wa] <= ifw.wd;
    if (ifd.regwrite) nxt_d[ifd.wa] <= ifd.wd;
  end

  int checks = 0;
  int failures = 0;
  int gen_exp = 0;
  logic [7:0] exp_rows [2][8];   // [0] toroidal, [1] dead border
  int exp_pop [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: count the eight neighbours of every cell directly on the 2-D board.
  task automatic compute_model();
    for (int w = 0; w < 2; w++) begin
      exp_pop[w] = 0;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          int n;
          bit alive, nb;
          n = 0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              int rr, cc;
              if (dr == 0 && dc == 0) continue;
              rr = r + dr;
              cc = c + dc;
              if (w == 0) begin
                rr = (rr + 8) % 8;
                cc = (cc + 8) % 8;
              end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                continue;
              end
              n += int'(cur[rr][cc]);
            end
          end
          alive = cur[r][c];
          nb = (n == 3) || (alive && n == 2);
          exp_rows[w][r][c] = nb;
          exp_pop[w] += int'(nb);
        end
      end
    end
  endtask

  task automatic get_outs(input int d, output logic [2:0] ra, output logic [2:0] wa,
                          output logic [7:0] wd, output logic rw, output logic bz,
                          output logic dn, output logic [6:0] pp, output logic [7:0] gn);
    if (d == 0) begin
      ra = ifw.ra; wa = ifw.wa; wd = ifw.wd; rw = ifw.regwrite;
      bz = ifw.busy; dn = ifw.done; pp = ifw.pop; gn = ifw.gen;
    end else begin
      ra = ifd.ra; wa = ifd.wa; wd = ifd.wd; rw = ifd.regwrite;
      bz = ifd.busy; dn = ifd.done; pp = ifd.pop; gn = ifd.gen;
    end
  endtask

  task automatic check_reset(input string tag);
    logic [2:0] ra, wa;
    logic [7:0] wd, gn;
    logic rw, bz, dn;
    logic [6:0] pp;
    for (int d = 0; d < 2; d++) begin
      get_outs(d, ra, wa, wd, rw, bz, dn, pp, gn);
      chk($sformatf("%s/d%0d/ra", tag, d), 32'(ra), 0);
      chk($sformatf("%s/d%0d/wa", tag, d), 32'(wa), 0);
      chk($sformatf("%s/d%0d/wd", tag, d), 32'(wd), 0);
      chk($sformatf("%s/d%0d/regwrite", tag, d), 32'(rw), 0);
      chk($sformatf("%s/d%0d/busy", tag, d), 32'(bz), 0);
      chk($sformatf("%s/d%0d/done", tag, d), 32'(dn), 0);
      chk($sformatf("%s/d%0d/pop", tag, d), 32'(pp), 0);
      chk($sformatf("%s/d%0d/gen", tag, d), 32'(gn), 0);
    end
  endtask

  // One pass: start at edge 0, check cycles 1..35. Optional start re-pulses in
  // cycles 5 and 33, optional reset asserted in cycle rst_cyc (pass abandoned).
  task automatic run_pass(input string tag, input bit repulse, input int rst_cyc);
    int nwr [2];
    bit aborted;
    logic [2:0] ra, wa;
    logic [7:0] wd, gn;
    logic rw, bz, dn;
    logic [6:0] pp;
    nwr[0] = 0;
    nwr[1] = 0;
    aborted = 0;
    compute_model();
    @(negedge ph1);
    ifw.start = 1'b1;
    ifd.start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      int ph, row, ra_e;
      @(negedge ph1);
      if (rst_cyc != 0 && k == rst_cyc + 1) begin
        check_reset({tag, "/midrst"});
        reset = 1'b1;
        aborted = 1;
        break;
      end
      ph = (k - 1) % 4;
      row = (k - 1) / 4;
      for (int d = 0; d < 2; d++) begin
        get_outs(d, ra, wa, wd, rw, bz, dn, pp, gn);
        ra_e = 0;
        if (k <= 32) begin
          if (ph == 0) ra_e = (row + 7) % 8;
          else if (ph == 1) ra_e = row;
          else if (ph == 2) ra_e = (row + 1) % 8;
        end
        chk($sformatf("%s/d%0d/k%0d/ra", tag, d, k), 32'(ra), 32'(ra_e));
        chk($sformatf("%s/d%0d/k%0d/regwrite", tag, d, k), 32'(rw), 32'(k <= 32 && ph == 3));
        chk($sformatf("%s/d%0d/k%0d/busy", tag, d, k), 32'(bz), 32'(k <= 32));
        chk($sformatf("%s/d%0d/k%0d/done", tag, d, k), 32'(dn), 32'(k == 33));
        if (rw) nwr[d]++;
        if (k <= 32 && ph == 3) begin
          chk($sformatf("%s/d%0d/k%0d/wa", tag, d, k), 32'(wa), 32'(row));
          chk($sformatf("%s/d%0d/k%0d/wd", tag, d, k), 32'(wd), 32'(exp_rows[d][row]));
        end
        if (k == 33) begin
          chk($sformatf("%s/d%0d/pop", tag, d), 32'(pp), 32'(exp_pop[d]));
          chk($sformatf("%s/d%0d/gen", tag, d), 32'(gn), 32'((gen_exp + 1) % 256));
        end
        if (k == 35) begin
          chk($sformatf("%s/d%0d/wa_hold", tag, d), 32'(wa), 7);
          chk($sformatf("%s/d%0d/wd_hold", tag, d), 32'(wd), 32'(exp_rows[d][7]));
        end
      end
      if (k == 1) begin
        ifw.start = 1'b0;
        ifd.start = 1'b0;
      end
      if (repulse && (k == 5 || k == 33)) begin
        ifw.start = 1'b1;
        ifd.start = 1'b1;
      end
      if (repulse && (k == 6 || k == 34)) begin
        ifw.start = 1'b0;
        ifd.start = 1'b0;
      end
      if (rst_cyc != 0 && k == rst_cyc) reset = 1'b0;
    end
    if (aborted) begin
      gen_exp = 0;
    end else begin
      chk({tag, "/d0/nwrites"}, 32'(nwr[0]), 8);
      chk({tag, "/d1/nwrites"}, 32'(nwr[1]), 8);
      gen_exp = (gen_exp + 1) % 256;
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < 8; r++) cur[r] = 8'h00;
  endtask

  initial begin
    logic [7:0] want;
    reset = 1'b0;
    ifw.start = 1'b0;
    ifd.start = 1'b0;
    clear_board();
    repeat (3) @(negedge ph1);
    check_reset("por");
    reset = 1'b1;

    // Blinker: vertical phase, then back to horizontal via the written file.
    clear_board();
    cur[3] = 8'h1C;
    run_pass("blink1", 1'b0, 0);
    for (int r = 0; r < 8; r++) begin
      want = (r >= 2 && r <= 4) ? 8'h08 : 8'h00;
      chk($sformatf("blink1/nxt%0d", r), 32'(nxt_w[r]), 32'(want));
    end
    chk("blink1/pop_const", 32'(ifw.pop), 3);
    for (int r = 0; r < 8; r++) cur[r] = nxt_w[r];
    run_pass("blink2", 1'b0, 0);
    chk("blink2/row3", 32'(nxt_w[3]), 32'h1C);
    chk("blink2/gen_const", 32'(ifw.gen), 2);

    // Block still life, with start re-pulsed mid-pass and during DONE.
    clear_board();
    cur[1] = 8'h06;
    cur[2] = 8'h06;
    run_pass("block", 1'b1, 0);
    chk("block/row1", 32'(nxt_w[1]), 32'h06);
    chk("block/gen_once", 32'(ifw.gen), 3);

    // All-ones board.
    for (int r = 0; r < 8; r++) cur[r] = 8'hFF;
    run_pass("ones", 1'b0, 0);
    chk("ones/wrap_pop", 32'(ifw.pop), 0);
    chk("ones/dead_pop", 32'(ifd.pop), 4);
    chk("ones/dead_row0", 32'(nxt_d[0]), 32'h81);
    chk("ones/dead_row7", 32'(nxt_d[7]), 32'h81);
    chk("ones/dead_row3", 32'(nxt_d[3]), 32'h00);

    // Corner-straddling row: exercises row and column wrap.
    clear_board();
    cur[0] = 8'h83;
    run_pass("edge", 1'b0, 0);
    chk("edge/row7", 32'(nxt_w[7]), 32'h01);
    chk("edge/row0", 32'(nxt_w[0]), 32'h01);
    chk("edge/row1", 32'(nxt_w[1]), 32'h01);
    chk("edge/pop", 32'(ifw.pop), 3);

    // Reset in cycle 10, then a normal pass.
    for (int r = 0; r < 8; r++) cur[r] = 8'($urandom);
    run_pass("midrst", 1'b0, 10);
    for (int r = 0; r < 8; r++) cur[r] = 8'($urandom);
    run_pass("after_rst", 1'b0, 0);

    // Random boards until the generation counter has wrapped past 255.
    for (int i = 0; i < 258; i++) begin
      for (int r = 0; r < 8; r++) cur[r] = 8'($urandom);
      if (i % 7 == 0) cur[$urandom_range(0, 7)] = 8'hFF;
      run_pass($sformatf("rnd%0d", i), (i % 5 == 0), 0);
    end
    chk("final/gen_wrapped", 32'(ifw.gen), 32'(gen_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
